// File: rtl/fp_wb_pkg.sv
// Shared constants and types for the FP writeback stage: flag bit order,
// CSR field layout, buffer depth and the buffered entry format.
package fp_wb_pkg;

    localparam int unsigned FP_WB_DEPTH = 2;

    localparam int unsigned RESULT_W = 32;
    localparam int unsigned DEST_W   = 5;
    localparam int unsigned FLAG_W   = 3;

    // Flag vector order: overflow, underflow, inexact.
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    // CSR layout: read {cause, enable, flags}, write {enable, flags}.
    localparam int unsigned CSR_FLAGS_LSB  = 0;
    localparam int unsigned CSR_ENABLE_LSB = 3;
    localparam int unsigned CSR_CAUSE_LSB  = 6;
    localparam int unsigned CSR_WDATA_W    = 6;
    localparam int unsigned CSR_RDATA_W    = 9;

    typedef logic [FLAG_W-1:0] flags_t;

    typedef struct packed {
        logic [RESULT_W-1:0] result;
        logic [DEST_W-1:0]   dest;
    } wb_entry_t;

    function automatic flags_t pack_flags(input logic of, input logic uf, input logic nx);
        flags_t f;
        f          = '0;
        f[FLAG_OF] = of;
        f[FLAG_UF] = uf;
        f[FLAG_NX] = nx;
        return f;
    endfunction

endpackage

// File: rtl/fp_wb_if.sv
// Bundle of the multiplier input, writeback, CSR and trap signals of the stage.
interface fp_wb_if;
    import fp_wb_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [RESULT_W-1:0]    in_result;
    logic                   in_overflow;
    logic                   in_underflow;
    logic                   in_inexact;
    logic [DEST_W-1:0]      in_dest;

    logic                   wb_valid;
    logic                   wb_ready;
    logic [RESULT_W-1:0]    wb_data;
    logic [DEST_W-1:0]      wb_dest;

    logic                   csr_we;
    logic [CSR_WDATA_W-1:0] csr_wdata;
    logic [CSR_RDATA_W-1:0] csr_rdata;

    logic                   trap;
    logic [DEST_W-1:0]      trap_dest;
    logic                   trap_ack;

    // Environment side: multiplier, register file and CSR/trap handler.
    modport master (
        output in_valid, in_result, in_overflow, in_underflow, in_inexact, in_dest,
        input  in_ready,
        input  wb_valid, wb_data, wb_dest,
        output wb_ready,
        output csr_we, csr_wdata,
        input  csr_rdata,
        input  trap, trap_dest,
        output trap_ack
    );

    // Writeback stage side.
    modport slave (
        input  in_valid, in_result, in_overflow, in_underflow, in_inexact, in_dest,
        output in_ready,
        output wb_valid, wb_data, wb_dest,
        input  wb_ready,
        input  csr_we, csr_wdata,
        output csr_rdata,
        output trap, trap_dest,
        input  trap_ack
    );

endinterface

// File: rtl/fp_wb_fifo.sv
// Two-entry in-order result buffer with 1-bit wrapping pointers.
module fp_wb_fifo
    import fp_wb_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  wb_entry_t i_wdata,
    output wb_entry_t o_rdata,
    output logic [1:0] o_count
);

    wb_entry_t  r_mem [2];
    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;

    logic       w_do_push;
    logic       w_do_pop;

    // Self-protect against push when full or pop when empty.
    assign w_do_push = i_push && (r_count != 2'd2);
    assign w_do_pop  = i_pop && (r_count != 2'd0);

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_do_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/fp_wb_stage.sv
// FP multiplier writeback stage: buffers results for the register file, keeps
// sticky exception flags, and raises a trap instead of writing back when an
// incoming flag is enabled.
module fp_wb_stage
    import fp_wb_pkg::*;
#(
    parameter int unsigned DEPTH = FP_WB_DEPTH
) (
    input  logic   clk,
    input  logic   rst,
    fp_wb_if.slave bus
);

    flags_t                 r_flags;
    flags_t                 r_enable;
    flags_t                 r_cause;
    logic                   r_trap;
    logic [DEST_W-1:0]      r_trap_dest;

    flags_t                 w_in_flags;
    flags_t                 w_new_flags;
    flags_t                 w_flags_d;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_hit;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_wb_valid;
    logic [1:0]             w_count;
    wb_entry_t              w_push_entry;
    wb_entry_t              w_head;
    logic [CSR_RDATA_W-1:0] w_csr_rdata;

    assign w_in_flags   = pack_flags(bus.in_overflow, bus.in_underflow, bus.in_inexact);
    assign w_in_ready   = !rst && (32'(w_count) < DEPTH) && !r_trap;
    assign w_accept     = bus.in_valid && w_in_ready;
    // Hit uses the enable register before any same-cycle CSR write.
    assign w_hit        = |(w_in_flags & r_enable);
    assign w_push       = w_accept && !w_hit;
    assign w_wb_valid   = !rst && (w_count != 2'd0);
    assign w_pop        = w_wb_valid && bus.wb_ready;
    assign w_push_entry = '{result: bus.in_result, dest: bus.in_dest};

    fp_wb_fifo u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_push_entry),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    // Next sticky flags: a CSR write replaces them but keeps same-cycle accept flags.
    always_comb begin
        w_new_flags = w_push ? w_in_flags : '0;
        if (bus.csr_we) begin
            w_flags_d = bus.csr_wdata[CSR_FLAGS_LSB +: FLAG_W] | w_new_flags;
        end else begin
            w_flags_d = r_flags | w_new_flags;
        end
    end

    // Flag, enable and cause registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags  <= '0;
            r_enable <= '0;
            r_cause  <= '0;
        end else begin
            r_flags <= w_flags_d;
            if (bus.csr_we) begin
                r_enable <= bus.csr_wdata[CSR_ENABLE_LSB +: FLAG_W];
            end
            if (w_accept) begin
                r_cause <= w_in_flags;
            end
        end
    end

    // Trap is raised by an enabled-flag accept and held until acknowledged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap      <= 1'b0;
            r_trap_dest <= '0;
        end else if (w_accept && w_hit) begin
            r_trap      <= 1'b1;
            r_trap_dest <= bus.in_dest;
        end else if (r_trap && bus.trap_ack) begin
            r_trap      <= 1'b0;
        end
    end

    // CSR read view assembled from the live registers.
    always_comb begin
        w_csr_rdata = '0;
        w_csr_rdata[CSR_CAUSE_LSB +: FLAG_W]  = r_cause;
        w_csr_rdata[CSR_ENABLE_LSB +: FLAG_W] = r_enable;
        w_csr_rdata[CSR_FLAGS_LSB +: FLAG_W]  = r_flags;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.wb_valid  = w_wb_valid;
    assign bus.wb_data   = w_head.result;
    assign bus.wb_dest   = w_head.dest;
    assign bus.csr_rdata = w_csr_rdata;
    // Masked during reset so no stale trap is visible before the registers clear.
    assign bus.trap      = r_trap && !rst;
    assign bus.trap_dest = r_trap_dest;

endmodule

// File: tb/tb_fp_wb_stage.sv
// Self-checking bench for fp_wb_stage: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fp_wb_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    fp_wb_if bus ();

    fp_wb_stage #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_result    = '0;
        bus.in_overflow  = 1'b0;
        bus.in_underflow = 1'b0;
        bus.in_inexact   = 1'b0;
        bus.in_dest      = '0;
        bus.wb_ready     = 1'b0;
        bus.csr_we       = 1'b0;
        bus.csr_wdata    = '0;
        bus.trap_ack     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_in_ready_during: got %b want 0", bus.in_ready); end
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_wb_valid_during: got %b want 0", bus.wb_valid); end
        n_tests++; if (bus.trap !== 1'b0) begin n_fail++;
            $display("FAIL reset_trap_during: got %b want 0", bus.trap); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_in_ready_after: got %b want 1", bus.in_ready); end
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_wb_valid_after: got %b want 0", bus.wb_valid); end
        n_tests++; if (bus.csr_rdata !== 9'h000) begin n_fail++;
            $display("FAIL reset_csr: got %h want 000", bus.csr_rdata); end
    endtask

    task automatic test_passthrough();
        do_reset();
        bus.wb_ready  = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_result = 32'h40C0_0000;
        bus.in_dest   = 5'd5;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL pass_in_ready: got %b want 1", bus.in_ready); end
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL pass_no_comb_path: got %b want 0", bus.wb_valid); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (bus.wb_valid !== 1'b1) begin n_fail++;
            $display("FAIL pass_wb_valid: got %b want 1", bus.wb_valid); end
        n_tests++; if (bus.wb_data !== 32'h40C0_0000) begin n_fail++;
            $display("FAIL pass_wb_data: got %h want 40c00000", bus.wb_data); end
        n_tests++; if (bus.wb_dest !== 5'd5) begin n_fail++;
            $display("FAIL pass_wb_dest: got %0d want 5", bus.wb_dest); end
        n_tests++; if (bus.csr_rdata[2:0] !== 3'b000) begin n_fail++;
            $display("FAIL pass_flags: got %b want 000", bus.csr_rdata[2:0]); end
        tick();
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL pass_drained: got %b want 0", bus.wb_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] res [3];
        for (int i = 0; i < 3; i++) res[i] = $urandom;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_result = res[i];
            bus.in_dest   = 5'(i + 1);
            #1;
            n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
                $display("FAIL bp_accept%0d: in_ready got %b want 1", i, bus.in_ready); end
            tick();
        end
        bus.in_result = res[2];
        bus.in_dest   = 5'd3;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
        tick();
        n_tests++; if (bus.wb_dest !== 5'd1 || bus.wb_data !== res[0] || bus.wb_valid !== 1'b1)
            begin n_fail++;
            $display("FAIL bp_stable_head: got v%b d%0d %h want v1 d1 %h",
                     bus.wb_valid, bus.wb_dest, bus.wb_data, res[0]); end
        bus.wb_ready = 1'b1;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_still_full: got %b want 0", bus.in_ready); end
        tick();
        n_tests++; if (bus.wb_dest !== 5'd2 || bus.wb_data !== res[1]) begin n_fail++;
            $display("FAIL bp_second_head: got d%0d %h want d2 %h",
                     bus.wb_dest, bus.wb_data, res[1]); end
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_ready_after_pop: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (bus.wb_valid !== 1'b1 || bus.wb_dest !== 5'd3 || bus.wb_data !== res[2])
            begin n_fail++;
            $display("FAIL bp_third_head: got v%b d%0d %h want v1 d3 %h",
                     bus.wb_valid, bus.wb_dest, bus.wb_data, res[2]); end
        tick();
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL bp_empty: got %b want 0", bus.wb_valid); end
    endtask

    task automatic test_trap();
        do_reset();
        bus.csr_we    = 1'b1;
        bus.csr_wdata = 6'b100_000;
        tick();
        bus.csr_we      = 1'b0;
        bus.wb_ready    = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_overflow = 1'b1;
        bus.in_dest     = 5'd7;
        #1;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL trap_in_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid    = 1'b0;
        bus.in_overflow = 1'b0;
        #1;
        n_tests++; if (bus.trap !== 1'b1 || bus.trap_dest !== 5'd7) begin n_fail++;
            $display("FAIL trap_raise: got t%b d%0d want t1 d7", bus.trap, bus.trap_dest); end
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL trap_no_wb: got %b want 0", bus.wb_valid); end
        n_tests++; if (bus.csr_rdata !== 9'b100_100_000) begin n_fail++;
            $display("FAIL trap_csr: got %b want 100100000", bus.csr_rdata); end
        n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++;
            $display("FAIL trap_blocks_input: got %b want 0", bus.in_ready); end
        tick();
        n_tests++; if (bus.trap !== 1'b1) begin n_fail++;
            $display("FAIL trap_held: got %b want 1", bus.trap); end
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        #1;
        n_tests++; if (bus.trap !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++;
            $display("FAIL trap_ack: got t%b r%b want t0 r1", bus.trap, bus.in_ready); end
    endtask

    task automatic test_sticky();
        do_reset();
        bus.wb_ready   = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_inexact = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.in_dest = 5'($urandom);
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.in_inexact = 1'b0;
        #1;
        n_tests++; if (bus.csr_rdata !== 9'b001_000_001) begin n_fail++;
            $display("FAIL sticky_set: got %b want 001000001", bus.csr_rdata); end
        bus.csr_we    = 1'b1;
        bus.csr_wdata = 6'b000_000;
        tick();
        bus.csr_we = 1'b0;
        #1;
        n_tests++; if (bus.csr_rdata !== 9'b001_000_000) begin n_fail++;
            $display("FAIL sticky_clear: got %b want 001000000", bus.csr_rdata); end
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        bus.wb_ready     = 1'b1;
        bus.csr_we       = 1'b1;
        bus.csr_wdata    = 6'b000_000;
        bus.in_valid     = 1'b1;
        bus.in_underflow = 1'b1;
        tick();
        bus.csr_we   = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (bus.csr_rdata !== 9'b010_000_010) begin n_fail++;
            $display("FAIL coll_flags: got %b want 010000010", bus.csr_rdata); end
        // Enabling underflow in the same cycle must not trap that accept.
        bus.csr_we    = 1'b1;
        bus.csr_wdata = 6'b010_000;
        bus.in_valid  = 1'b1;
        bus.in_dest   = 5'd12;
        tick();
        bus.csr_we = 1'b0;
        #1;
        n_tests++; if (bus.trap !== 1'b0 || bus.csr_rdata !== 9'b010_010_010) begin n_fail++;
            $display("FAIL coll_pre_enable: got t%b csr %b want t0 010010010",
                     bus.trap, bus.csr_rdata); end
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_tests++; if (bus.trap !== 1'b1 || bus.trap_dest !== 5'd12) begin n_fail++;
            $display("FAIL coll_post_enable: got t%b d%0d want t1 d12",
                     bus.trap, bus.trap_dest); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.in_valid   = 1'b1;
        bus.in_inexact = 1'b1;
        tick();
        tick();
        bus.in_valid   = 1'b0;
        bus.in_inexact = 1'b0;
        bus.csr_we     = 1'b1;
        bus.csr_wdata  = 6'b100_001;
        tick();
        bus.csr_we = 1'b0;
        #1;
        n_tests++; if (bus.in_ready !== 1'b0 || bus.wb_valid !== 1'b1) begin n_fail++;
            $display("FAIL mid_full_pre: got r%b v%b want r0 v1", bus.in_ready, bus.wb_valid); end
        rst          = 1'b1;
        bus.wb_ready = 1'b1;
        #1;
        n_tests++; if (bus.wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL mid_wb_during: got %b want 0", bus.wb_valid); end
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (bus.wb_valid !== 1'b0 || bus.trap !== 1'b0 || bus.in_ready !== 1'b1 ||
                       bus.csr_rdata !== 9'h000) begin n_fail++;
            $display("FAIL mid_after_full: got v%b t%b r%b csr %h want v0 t0 r1 000",
                     bus.wb_valid, bus.trap, bus.in_ready, bus.csr_rdata); end
        // Now a pending trap with one buffered entry.
        bus.wb_ready  = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_dest   = 5'd4;
        bus.csr_we    = 1'b1;
        bus.csr_wdata = 6'b100_000;
        tick();
        bus.csr_we      = 1'b0;
        bus.in_overflow = 1'b1;
        bus.in_dest     = 5'd9;
        tick();
        bus.in_valid    = 1'b0;
        bus.in_overflow = 1'b0;
        #1;
        n_tests++; if (bus.trap !== 1'b1 || bus.wb_valid !== 1'b1) begin n_fail++;
            $display("FAIL mid_trap_pre: got t%b v%b want t1 v1", bus.trap, bus.wb_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_tests++; if (bus.wb_valid !== 1'b0 || bus.trap !== 1'b0 || bus.in_ready !== 1'b1 ||
                       bus.csr_rdata !== 9'h000) begin n_fail++;
            $display("FAIL mid_after_trap: got v%b t%b r%b csr %h want v0 t0 r1 000",
                     bus.wb_valid, bus.trap, bus.in_ready, bus.csr_rdata); end
    endtask

    task automatic test_random();
        logic [36:0] q[$];
        logic [2:0]  m_flags;
        logic [2:0]  m_enable;
        logic [2:0]  m_cause;
        logic        m_trap;
        logic [4:0]  m_trap_dest;
        logic        exp_ready;
        logic        exp_wb_valid;
        logic        exp_trap;
        logic        accept;
        logic        hit;
        logic [2:0]  inf;
        logic [2:0]  pushed;

        do_reset();
        q.delete();
        m_flags = '0; m_enable = '0; m_cause = '0; m_trap = 1'b0; m_trap_dest = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst              = ($urandom_range(0, 99) == 0);
            bus.in_valid     = ($urandom_range(0, 9) < 6);
            bus.in_result    = $urandom;
            bus.in_dest      = 5'($urandom);
            bus.in_overflow  = ($urandom_range(0, 9) == 0);
            bus.in_underflow = ($urandom_range(0, 9) == 0);
            bus.in_inexact   = ($urandom_range(0, 4) == 0);
            bus.wb_ready     = ($urandom_range(0, 9) < 6);
            bus.csr_we       = ($urandom_range(0, 19) == 0);
            bus.csr_wdata    = 6'($urandom);
            bus.trap_ack     = ($urandom_range(0, 2) == 0);
            #1;
            exp_ready    = !rst && (q.size() < 2) && !m_trap;
            exp_wb_valid = !rst && (q.size() > 0);
            exp_trap     = !rst && m_trap;
            n_tests++; if (bus.in_ready !== exp_ready) begin n_fail++;
                $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, bus.in_ready, exp_ready); end
            n_tests++; if (bus.wb_valid !== exp_wb_valid) begin n_fail++;
                $display("FAIL rnd_wb_valid c%0d: got %b want %b",
                         cyc, bus.wb_valid, exp_wb_valid); end
            if (exp_wb_valid) begin
                n_tests++; if ({bus.wb_data, bus.wb_dest} !== q[0]) begin n_fail++;
                    $display("FAIL rnd_wb_head c%0d: got %h want %h",
                             cyc, {bus.wb_data, bus.wb_dest}, q[0]); end
            end
            n_tests++; if (bus.trap !== exp_trap) begin n_fail++;
                $display("FAIL rnd_trap c%0d: got %b want %b", cyc, bus.trap, exp_trap); end
            if (exp_trap) begin
                n_tests++; if (bus.trap_dest !== m_trap_dest) begin n_fail++;
                    $display("FAIL rnd_trap_dest c%0d: got %0d want %0d",
                             cyc, bus.trap_dest, m_trap_dest); end
            end
            n_tests++; if (bus.csr_rdata !== {m_cause, m_enable, m_flags}) begin n_fail++;
                $display("FAIL rnd_csr c%0d: got %b want %b",
                         cyc, bus.csr_rdata, {m_cause, m_enable, m_flags}); end

            if (rst) begin
                q.delete();
                m_flags = '0; m_enable = '0; m_cause = '0; m_trap = 1'b0; m_trap_dest = '0;
            end else begin
                inf    = {bus.in_overflow, bus.in_underflow, bus.in_inexact};
                accept = bus.in_valid && exp_ready;
                hit    = (inf & m_enable) != 3'b000;
                pushed = (accept && !hit) ? inf : 3'b000;
                if (exp_wb_valid && bus.wb_ready) void'(q.pop_front());
                if (accept && !hit) q.push_back({bus.in_result, bus.in_dest});
                if (bus.csr_we) begin
                    m_enable = bus.csr_wdata[5:3];
                    m_flags  = bus.csr_wdata[2:0] | pushed;
                end else begin
                    m_flags = m_flags | pushed;
                end
                if (accept) m_cause = inf;
                if (accept && hit) begin
                    m_trap      = 1'b1;
                    m_trap_dest = bus.in_dest;
                end else if (m_trap && bus.trap_ack) begin
                    m_trap = 1'b0;
                end
            end
            tick();
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        idle();
        test_reset();
        test_passthrough();
        test_backpressure();
        test_trap();
        test_sticky();
        test_collision();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_wb_stage.md
FP_WB_STAGE -- requirements
Module: fp_wb_stage

Interface
REQ-001 Parameter: DEPTH, default 2, number of result-buffer entries; only the value 2 is supported.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  the FP multiplier offers a result this cycle.
REQ-005 in_ready  output  1  the stage accepts the offered result this cycle.
REQ-006 in_result  input  32  IEEE-754 single-precision product.
REQ-007 in_overflow, in_underflow, in_inexact  input  1 each  exception flags for in_result.
REQ-008 in_dest  input  5  destination FP register index.
REQ-009 wb_valid  output  1  the buffer head is valid for register-file writeback.
REQ-010 wb_ready  input  1  the register file accepts the head.
REQ-011 wb_data  output  32, wb_dest  output  5  head result and its destination.
REQ-012 csr_we  input  1, csr_wdata  input  6  writes {enable[2:0], flags[2:0]}.
REQ-013 csr_rdata  output  9  {cause[2:0], enable[2:0], flags[2:0]}, combinational from registers.
REQ-014 trap  output  1  an enabled FP exception is pending.
REQ-015 trap_dest  output  5  destination of the trapping result.
REQ-016 trap_ack  input  1  the exception handler has taken the trap.

Function
REQ-017 Flag vector order everywhere: bit2 overflow, bit1 underflow, bit0 inexact.
REQ-018 Accept occurs when in_valid && in_ready; in_ready = !rst && (count < DEPTH) && !trap.
REQ-019 On every accept, cause <= {in_overflow, in_underflow, in_inexact}.
REQ-020 hit = |(incoming flags & enable); if hit on accept: no enqueue, trap <= 1, trap_dest <= in_dest, flags unchanged.
REQ-021 If no hit on accept: enqueue {in_result, in_dest}; flags <= flags | incoming flags.
REQ-022 Latency: a result accepted in cycle N into an empty buffer has wb_valid = 1 in cycle N+1; no combinational in-to-wb path.
REQ-023 Pop occurs when wb_valid && wb_ready; the head advances in order, FIFO semantics.
REQ-024 Simultaneous push and pop at count = 1: count stays 1, and the new entry becomes the head next cycle.
REQ-025 Count = DEPTH: in_ready = 0; wb outputs stay stable while wb_ready = 0.
REQ-026 wb_valid = 0 when empty; wb_data and wb_dest are don't-care then.
REQ-027 Read and write pointers are 1-bit and wrap from 1 to 0; count is 0..2.
REQ-028 trap stays 1 until a cycle with trap_ack = 1; it clears on the next edge. trap_ack while trap = 0 is ignored.
REQ-029 While trap = 1, the buffer keeps draining normally.
REQ-030 csr_we: enable <= csr_wdata[5:3]; flags <= csr_wdata[2:0] | flags from a same-cycle non-trapping accept.
REQ-031 A same-cycle csr_we and accept evaluate hit with the pre-write enable.
REQ-032 cause is not CSR-writable.

Reset
REQ-033 When rst is high at an edge: count, pointers, flags, enable, cause, trap and trap_dest <= 0.
REQ-034 During and after reset: wb_valid = 0 and trap = 0; in_ready = 0 while rst is high and 1 in the first cycle after.
REQ-035 A reset during a pending push, pop or trap discards the entries and the trap with no writeback.

Structure
REQ-036 The shared package fp_wb_pkg holds the flag bit indices, the CSR field positions and DEPTH.
REQ-037 A single sub-module, fp_wb_fifo, is natural: 2-entry, 37-bit-wide, push/pop/count, same clk/rst.
REQ-038 The flag, enable, cause and trap registers live in the top module.

Verification
REQ-039 Pass-through: in_result = 32'h40C00000, dest 5, flags 0, wb_ready = 1 -> the next cycle shows wb_valid = 1, wb_data = 32'h40C00000, wb_dest = 5, flags = 0.
REQ-040 Backpressure: wb_ready = 0, push dests 1, 2, 3 -> 1 and 2 are accepted and in_ready = 0 on the third; raise wb_ready -> pops 1 then 2, then 3 is accepted.
REQ-041 Trap: enable = 3'b100, push with in_overflow = 1, dest 7 -> trap = 1, trap_dest = 7, no wb, cause = 3'b100, flags = 0; trap_ack -> trap = 0 and in_ready = 1.
REQ-042 Sticky flags: two pushes with in_inexact = 1 -> flags = 3'b001; csr_we with csr_wdata = 6'b000000 -> flags = 0.
REQ-043 CSR/accept collision: csr_we with data 6'b000000 and a same-cycle accept with in_underflow = 1 -> flags = 3'b010.
REQ-044 Reset mid-stream: count = 2 and trap = 1, assert rst for one cycle -> wb_valid = 0, trap = 0, csr_rdata = 0, in_ready = 1 afterwards.
